// File: rtl/kamus_ex_unit.sv
`default_nettype none
// ============================================================================
// kamus_ex_unit : handshaked execute stage with iterative multiply/divide
// Rev 1.0
// ============================================================================
module kamus_ex_unit #(
  parameter int XLEN = 32,
  parameter int OP_W = 5,
  parameter int EN_M = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [OP_W-1:0] op_i,
  input  logic            imm_used_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN) + 1;
  localparam bit c_M_EN = (EN_M != 0);

  localparam logic [OP_W-1:0] c_OP_ADD    = OP_W'(0);
  localparam logic [OP_W-1:0] c_OP_SUB    = OP_W'(1);
  localparam logic [OP_W-1:0] c_OP_SLT    = OP_W'(2);
  localparam logic [OP_W-1:0] c_OP_SLTU   = OP_W'(3);
  localparam logic [OP_W-1:0] c_OP_XOR    = OP_W'(4);
  localparam logic [OP_W-1:0] c_OP_OR     = OP_W'(5);
  localparam logic [OP_W-1:0] c_OP_AND    = OP_W'(6);
  localparam logic [OP_W-1:0] c_OP_SLL    = OP_W'(7);
  localparam logic [OP_W-1:0] c_OP_SRL    = OP_W'(8);
  localparam logic [OP_W-1:0] c_OP_SRA    = OP_W'(9);
  localparam logic [OP_W-1:0] c_OP_LUI    = OP_W'(10);
  localparam logic [OP_W-1:0] c_OP_AUIPC  = OP_W'(11);
  localparam logic [OP_W-1:0] c_OP_JAL    = OP_W'(12);
  localparam logic [OP_W-1:0] c_OP_MUL    = OP_W'(13);
  localparam logic [OP_W-1:0] c_OP_MULH   = OP_W'(14);
  localparam logic [OP_W-1:0] c_OP_MULHSU = OP_W'(15);
  localparam logic [OP_W-1:0] c_OP_MULHU  = OP_W'(16);
  localparam logic [OP_W-1:0] c_OP_DIV    = OP_W'(17);
  localparam logic [OP_W-1:0] c_OP_DIVU   = OP_W'(18);
  localparam logic [OP_W-1:0] c_OP_REM    = OP_W'(19);
  localparam logic [OP_W-1:0] c_OP_REMU   = OP_W'(20);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_out_valid;
  logic [XLEN-1:0]       r_result;
  logic [2*XLEN-1:0]     r_acc;
  logic [XLEN-1:0]       r_opb;
  logic [CW-1:0]         r_cnt;
  logic                  r_neg;
  logic [OP_W-1:0]       r_op;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_is_mul;
  logic                  w_is_div;
  logic                  w_is_m;
  logic [XLEN-1:0]       w_opb;
  logic [SHW-1:0]        w_shamt;
  logic [XLEN-1:0]       w_alu;
  logic                  w_a_signed;
  logic                  w_b_signed;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [XLEN-1:0]       w_a_mag;
  logic [XLEN-1:0]       w_b_mag;
  logic                  w_res_neg;
  logic                  w_div_zero;
  logic                  w_div_ovf;
  logic                  w_special;
  logic [XLEN-1:0]       w_special_res;
  logic [XLEN:0]         w_mul_sum;
  logic [2*XLEN-1:0]     w_mul_step;
  logic [XLEN:0]         w_div_shift;
  logic                  w_div_ge;
  logic [XLEN-1:0]       w_div_sub;
  logic [2*XLEN-1:0]     w_div_step;
  logic [2*XLEN-1:0]     w_prod_fix;
  logic [XLEN-1:0]       w_quo_fix;
  logic [XLEN-1:0]       w_rem_fix;
  logic [XLEN-1:0]       w_m_result;

  assign w_in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready_i);
  assign w_accept    = in_valid_i && w_in_ready && !flush_i;
  assign in_ready_o  = w_in_ready;
  assign out_valid_o = r_out_valid;
  assign result_o    = r_result;
  assign busy_o      = (r_state == S_MUL) || (r_state == S_DIV);

  assign w_is_mul = (op_i >= c_OP_MUL) && (op_i <= c_OP_MULHU);
  assign w_is_div = (op_i >= c_OP_DIV) && (op_i <= c_OP_REMU);
  assign w_is_m   = w_is_mul || w_is_div;

  // SUB and M-ops always take rs2 even when an immediate is flagged
  assign w_opb   = (imm_used_i && (op_i != c_OP_SUB) && !w_is_m) ? imm_i : rs2_i;
  assign w_shamt = w_opb[SHW-1:0];

  always_comb begin
    w_alu = '0;
    case (op_i)
      c_OP_ADD:   w_alu = rs1_i + w_opb;
      c_OP_SUB:   w_alu = rs1_i - w_opb;
      c_OP_SLT:   w_alu = {{(XLEN-1){1'b0}}, ($signed(rs1_i) < $signed(w_opb))};
      c_OP_SLTU:  w_alu = {{(XLEN-1){1'b0}}, (rs1_i < w_opb)};
      c_OP_XOR:   w_alu = rs1_i ^ w_opb;
      c_OP_OR:    w_alu = rs1_i | w_opb;
      c_OP_AND:   w_alu = rs1_i & w_opb;
      c_OP_SLL:   w_alu = rs1_i << w_shamt;
      c_OP_SRL:   w_alu = rs1_i >> w_shamt;
      c_OP_SRA:   w_alu = $unsigned($signed(rs1_i) >>> w_shamt);
      c_OP_LUI:   w_alu = imm_i;
      c_OP_AUIPC: w_alu = pc_i + imm_i;
      c_OP_JAL:   w_alu = pc_i + XLEN'(4);
      default:    w_alu = '0;
    endcase
  end

  assign w_a_signed = (op_i == c_OP_MULH) || (op_i == c_OP_MULHSU) ||
                      (op_i == c_OP_DIV)  || (op_i == c_OP_REM);
  assign w_b_signed = (op_i == c_OP_MULH) || (op_i == c_OP_DIV) || (op_i == c_OP_REM);
  assign w_a_neg    = w_a_signed && rs1_i[XLEN-1];
  assign w_b_neg    = w_b_signed && rs2_i[XLEN-1];
  assign w_a_mag    = w_a_neg ? (-rs1_i) : rs1_i;
  assign w_b_mag    = w_b_neg ? (-rs2_i) : rs2_i;
  // Remainder follows the dividend sign; everything else follows the XOR
  assign w_res_neg  = (op_i == c_OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div_zero = (rs2_i == '0);
  assign w_div_ovf  = ((op_i == c_OP_DIV) || (op_i == c_OP_REM)) &&
                      (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
  assign w_special  = w_is_div && (w_div_zero || w_div_ovf);

  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = ((op_i == c_OP_DIV) || (op_i == c_OP_DIVU)) ? '1 : rs1_i;
    end else if (w_div_ovf) begin
      w_special_res = (op_i == c_OP_DIV) ? rs1_i : '0;
    end
  end

  // Shift-add: multiplier sits in the low half and is consumed LSB first
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opb : '0)};
  assign w_mul_step = {w_mul_sum, r_acc[XLEN-1:1]};

  // Restoring divide: high half is the partial remainder, low half shifts
  // the dividend out and the quotient bits in
  assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
  assign w_div_sub   = w_div_shift[XLEN-1:0] - r_opb;
  assign w_div_step  = {(w_div_ge ? w_div_sub : w_div_shift[XLEN-1:0]),
                        r_acc[XLEN-2:0], w_div_ge};

  assign w_prod_fix = r_neg ? (-r_acc) : r_acc;
  assign w_quo_fix  = r_neg ? (-r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
  assign w_rem_fix  = r_neg ? (-r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_m_result = '0;
    case (r_op)
      c_OP_MUL:                           w_m_result = w_prod_fix[XLEN-1:0];
      c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_m_result = w_prod_fix[2*XLEN-1:XLEN];
      c_OP_DIV, c_OP_DIVU:                w_m_result = w_quo_fix;
      c_OP_REM, c_OP_REMU:                w_m_result = w_rem_fix;
      default:                            w_m_result = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && c_M_EN && w_is_mul) begin
          w_state_next = S_MUL;
        end else if (w_accept && c_M_EN && w_is_div && !w_special) begin
          w_state_next = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (r_cnt == CW'(1)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (flush_i) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_acc       <= '0;
      r_opb       <= '0;
      r_cnt       <= '0;
      r_neg       <= 1'b0;
      r_op        <= '0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (c_M_EN && w_is_m) begin
              if (w_special) begin
                r_result    <= w_special_res;
                r_out_valid <= 1'b1;
              end else begin
                r_out_valid <= 1'b0;
                r_acc       <= {{XLEN{1'b0}}, (w_is_mul ? w_b_mag : w_a_mag)};
                r_opb       <= w_is_mul ? w_a_mag : w_b_mag;
                r_cnt       <= CW'(XLEN);
                r_neg       <= w_res_neg;
                r_op        <= op_i;
              end
            end else begin
              r_result    <= w_alu;
              r_out_valid <= 1'b1;
            end
          end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
          end
        end
        S_MUL: begin
          r_acc <= w_mul_step;
          r_cnt <= r_cnt - CW'(1);
        end
        S_DIV: begin
          r_acc <= w_div_step;
          r_cnt <= r_cnt - CW'(1);
        end
        S_DONE: begin
          r_result    <= w_m_result;
          r_out_valid <= 1'b1;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kamus_ex_unit.sv
`default_nettype none
// ============================================================================
// tb_kamus_ex_unit : directed scoreboard bench for the kamus execute stage
// Rev 1.0
// ============================================================================
module tb_kamus_ex_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic            imm_used;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  int              n_vec = 0;
  int              n_err = 0;
  logic [XLEN-1:0] sb_q[$];

  kamus_ex_unit #(.XLEN(XLEN), .OP_W(5), .EN_M(1)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .imm_used_i  (imm_used),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .imm_i       (imm),
    .pc_i        (pc),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] sb_pop();
    logic [XLEN-1:0] v;
    v = '0;
    if (sb_q.size() > 0) v = sb_q.pop_front();
    return v;
  endfunction

  // Issue one op with downstream ready, then measure latency, busy time and result
  task automatic run_op(input logic [4:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic iu, input logic [XLEN-1:0] im, input logic [XLEN-1:0] p,
                        input logic [XLEN-1:0] exp, input int lat, input string tag);
    int cyc;
    int busy_n;
    op = o; rs1 = a; rs2 = b; imm_used = iu; imm = im; pc = p;
    in_valid = 1'b1; out_ready = 1'b1;
    check({tag, "/in_ready"}, XLEN'(in_ready), XLEN'(1));
    sb_q.push_back(exp);
    step();
    in_valid = 1'b0;
    cyc = 1;
    busy_n = 0;
    while (!out_valid && cyc < 100) begin
      if (busy) busy_n++;
      step();
      cyc++;
    end
    check({tag, "/latency"}, XLEN'(cyc), XLEN'(lat));
    check({tag, "/busy_cycles"}, XLEN'(busy_n), XLEN'((lat == XLEN + 2) ? XLEN : 0));
    check({tag, "/result"}, out_valid ? result : 'x, sb_pop());
    step();
    check({tag, "/drained"}, XLEN'(out_valid), XLEN'(0));
  endtask

  initial begin
    int vcount;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0; imm_used = 1'b0;
    rs1 = '0; rs2 = '0; imm = '0; pc = '0; out_ready = 1'b1;
    #2;
    check("reset/out_valid", XLEN'(out_valid), XLEN'(0));
    check("reset/result", result, '0);
    check("reset/busy", XLEN'(busy), XLEN'(0));
    @(negedge clk);
    rst = 1'b0;
    step();

    // Single-cycle ALU
    run_op(5'd0,  32'hFFFF_FFFF, 32'h1,         1'b0, 32'h0,         32'h0,    32'h0000_0000, 1, "add_wrap");
    run_op(5'd0,  32'd10,        32'd99,        1'b1, 32'hFFFF_FFFD, 32'h0,    32'd7,         1, "add_imm");
    run_op(5'd1,  32'd5,         32'd7,         1'b1, 32'd1,         32'h0,    32'hFFFF_FFFE, 1, "sub_ignores_imm");
    run_op(5'd2,  32'hFFFF_FFFF, 32'd1,         1'b0, 32'h0,         32'h0,    32'd1,         1, "slt");
    run_op(5'd3,  32'hFFFF_FFFF, 32'd1,         1'b0, 32'h0,         32'h0,    32'd0,         1, "sltu");
    run_op(5'd4,  32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 32'h0,         32'h0,    32'hFF00_ED34, 1, "xor");
    run_op(5'd5,  32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 32'h0,         32'h0,    32'hFFF0_FF34, 1, "or");
    run_op(5'd6,  32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 32'h0,         32'h0,    32'h00F0_1200, 1, "and");
    run_op(5'd7,  32'd1,         32'h21,        1'b0, 32'h0,         32'h0,    32'd2,         1, "sll_mask");
    run_op(5'd8,  32'h8000_0000, 32'd4,         1'b0, 32'h0,         32'h0,    32'h0800_0000, 1, "srl");
    run_op(5'd9,  32'h8000_0000, 32'd0,         1'b1, 32'd4,         32'h0,    32'hF800_0000, 1, "sra_imm");
    run_op(5'd10, 32'h0,         32'h0,         1'b1, 32'h1234_5000, 32'h0,    32'h1234_5000, 1, "lui");
    run_op(5'd11, 32'h0,         32'h0,         1'b1, 32'h0000_2000, 32'h1000, 32'h0000_3000, 1, "auipc");
    run_op(5'd12, 32'h0,         32'h0,         1'b0, 32'h0,         32'h1000, 32'h0000_1004, 1, "jal");
    run_op(5'd25, 32'h1234,      32'h5678,      1'b0, 32'h0,         32'h0,    32'h0,         1, "illegal");

    // Iterative multiply/divide
    run_op(5'd13, 32'd7,         32'hFFFF_FFFD, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFEB, XLEN + 2, "mul");
    run_op(5'd14, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 32'h4000_0000, XLEN + 2, "mulh");
    run_op(5'd15, 32'hFFFF_FFFF, 32'd2,         1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, XLEN + 2, "mulhsu");
    run_op(5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFE, XLEN + 2, "mulhu");
    run_op(5'd17, 32'hFFFF_FFF9, 32'd2,         1'b0, 32'h0, 32'h0, 32'hFFFF_FFFD, XLEN + 2, "div_neg");
    run_op(5'd19, 32'hFFFF_FFF9, 32'd2,         1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, XLEN + 2, "rem_neg");
    run_op(5'd17, 32'd20,        32'hFFFF_FFFA, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFD, XLEN + 2, "div_negdivisor");
    run_op(5'd19, 32'd20,        32'hFFFF_FFFA, 1'b0, 32'h0, 32'h0, 32'd2,         XLEN + 2, "rem_negdivisor");
    run_op(5'd18, 32'd100,       32'd7,         1'b0, 32'h0, 32'h0, 32'd14,        XLEN + 2, "divu");
    run_op(5'd20, 32'd100,       32'd7,         1'b0, 32'h0, 32'h0, 32'd2,         XLEN + 2, "remu");

    // Divide special cases resolve in one cycle
    run_op(5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 32'h8000_0000, 1, "div_ovf");
    run_op(5'd19, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 32'h0,         1, "rem_ovf");
    run_op(5'd18, 32'd7,         32'd0,         1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1, "divu_zero");
    run_op(5'd20, 32'd7,         32'd0,         1'b0, 32'h0, 32'h0, 32'd7,         1, "remu_zero");
    run_op(5'd17, 32'hFFFF_FFF0, 32'd0,         1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1, "div_zero");

    // Back-to-back single-cycle ops at full throughput
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        op = 5'd0; rs1 = XLEN'(i * 16); rs2 = 32'd3; imm_used = 1'b0; in_valid = 1'b1;
        sb_q.push_back(XLEN'(i * 16 + 3));
        check("b2b/in_ready", XLEN'(in_ready), XLEN'(1));
      end else begin
        in_valid = 1'b0;
      end
      if (i > 0) begin
        check("b2b/out_valid", XLEN'(out_valid), XLEN'(1));
        check("b2b/result", result, sb_pop());
      end
      step();
    end
    check("b2b/drained", XLEN'(out_valid), XLEN'(0));

    // Backpressure: result held, a second op waits
    out_ready = 1'b0;
    op = 5'd0; rs1 = 32'h10; rs2 = 32'h20; in_valid = 1'b1;
    sb_q.push_back(32'h30);
    step();
    rs1 = 32'h1; rs2 = 32'h1;
    for (int i = 0; i < 5; i++) begin
      check("hold/out_valid", XLEN'(out_valid), XLEN'(1));
      check("hold/result", result, 32'h30);
      check("hold/in_ready", XLEN'(in_ready), XLEN'(0));
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("hold/release", result, sb_pop());
    step();
    check("hold/drained", XLEN'(out_valid), XLEN'(0));

    // Flush in the middle of a divide
    op = 5'd18; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush/in_ready", XLEN'(in_ready), XLEN'(1));
    check("flush/out_valid", XLEN'(out_valid), XLEN'(0));
    check("flush/busy", XLEN'(busy), XLEN'(0));
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) vcount++;
      step();
    end
    check("flush/no_result", XLEN'(vcount), XLEN'(0));

    // Op presented together with flush is dropped
    op = 5'd13; rs1 = 32'd3; rs2 = 32'd5; in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_drop/out_valid", XLEN'(out_valid), XLEN'(0));
    check("flush_drop/busy", XLEN'(busy), XLEN'(0));

    // Asynchronous reset while multiplying
    op = 5'd13; rs1 = 32'd3; rs2 = 32'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("prereset/busy", XLEN'(busy), XLEN'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst/out_valid", XLEN'(out_valid), XLEN'(0));
    check("async_rst/result", result, '0);
    check("async_rst/busy", XLEN'(busy), XLEN'(0));
    @(negedge clk);
    rst = 1'b0;
    step();
    run_op(5'd13, 32'd3, 32'd5, 1'b0, 32'h0, 32'h0, 32'd15, XLEN + 2, "mul_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kamus_ex_unit.md
Name: kamus_ex_unit

Overview:
- Parametrised, handshaked execute stage for the kamus core; successor of the single-cycle combinational EX ALU.
- Adds registered output, valid/ready flow control and pipeline flush.
- Adds iterative RV32M/RV64M multiply/divide (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits between the ID/regfile-read stage and the MEM/WB stage.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- OP_W, 5, width of the operation code.
- EN_M, 1, 1 enables the multiply/divide engine; 0 makes M-ops return 0 in one cycle.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  kill in-flight and output-held operation.
- in_valid_i  in  1  operation presented.
- in_ready_o  out  1  operation accepted this cycle when high with in_valid_i.
- op_i  in  OP_W  operation code: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA, 10 LUI, 11 AUIPC, 12 JAL/JALR, 13 MUL, 14 MULH, 15 MULHSU, 16 MULHU, 17 DIV, 18 DIVU, 19 REM, 20 REMU; others are illegal.
- imm_used_i  in  1  use imm_i in place of rs2_i as operand B (not for SUB or M-ops).
- rs1_i  in  XLEN  operand A.
- rs2_i  in  XLEN  operand B.
- imm_i  in  XLEN  sign-extended immediate.
- pc_i  in  XLEN  instruction PC.
- out_valid_o  out  1  result_o valid.
- out_ready_i  in  1  downstream accepts result.
- result_o  out  XLEN  registered result.
- busy_o  out  1  multi-cycle engine active.

Behaviour:
- Reset (async assert, sync release): state IDLE, out_valid_o=0, result_o=0, busy_o=0, cycle counter=0.
- Accept condition: in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i). Accept = in_valid_i && in_ready_o && !flush_i.
- Single-cycle ops (0-12):
  - Result is registered on the accept edge; out_valid_o is high on the next cycle (latency 1).
  - Back-to-back throughput is 1 per cycle while out_ready_i=1.
- Single-cycle arithmetic:
  - Results wrap mod 2^XLEN.
  - SLT/SLTU zero-extend the 1-bit compare.
  - Shift amount = operand B[log2(XLEN)-1:0].
  - SRA is arithmetic.
  - LUI returns imm_i.
  - AUIPC returns pc_i + imm_i.
  - JAL/JALR returns pc_i + 4.
- M-ops (EN_M=1), FSM IDLE -> MUL or DIV -> DONE -> IDLE:
  - On accept: latch operands, convert signed operands to magnitude, record result sign, counter = XLEN, busy_o = 1.
  - MUL: shift-add, one bit per cycle, 2*XLEN accumulator, XLEN cycles.
  - DIV: restoring division, one quotient bit per cycle, XLEN cycles.
  - DONE: apply sign correction, select low/high product or quotient/remainder, register result_o, assert out_valid_o, clear busy_o, return to IDLE.
  - Latency from accept to out_valid_o is XLEN+2 cycles.
- Divide special cases (decided at accept, no iteration):
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return the dividend.
  - Signed overflow (-2^(XLEN-1) / -1): DIV returns the dividend; REM returns 0.
  - In both cases out_valid_o is high on the next cycle.
- Output hold: while out_valid_o && !out_ready_i, result_o is stable and no new accept occurs.
- Flush:
  - flush_i=1 forces state IDLE, out_valid_o=0, busy_o=0 on the next edge.
  - An op presented during the same cycle as flush_i is dropped.
  - Flush has priority over completion.
- Illegal op codes are accepted and return 0 with latency 1.

Test Plan:
- ADD rs1=0xFFFFFFFF, rs2=1, in_valid one cycle, out_ready=1 -> next cycle out_valid=1, result=0x00000000.
- SRA rs1=0x80000000, imm_used=1, imm=4 -> result=0xF8000000.
- MULH rs1=0x80000000, rs2=0x80000000 -> busy for 32 cycles, result=0x40000000 at accept+34.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> result=0x80000000 at accept+1; REM with the same operands -> 0.
- DIVU rs1=7, rs2=0 -> 0xFFFFFFFF; REMU rs1=7, rs2=0 -> 7.
- Backpressure and flush:
  - ADD with out_ready=0 for 5 cycles -> result held, in_ready=0 throughout.
  - DIVU 100/7 with flush_i asserted at cycle 10 -> no out_valid, in_ready=1 the next cycle.
  - Async rst_i asserted mid-MUL -> all outputs 0 immediately.
